// File: rtl/instr_encoder_pkg.sv
// Shared types, opcode constants and immediate range helpers for the LEGv8 instruction encoder.
package instr_encoder_pkg;

  typedef enum logic [2:0] {
    OP_LDUR    = 3'd0,
    OP_STUR    = 3'd1,
    OP_CBZ     = 3'd2,
    OP_ADD     = 3'd3,
    OP_SUB     = 3'd4,
    OP_AND     = 3'd5,
    OP_ORR     = 3'd6,
    OP_ILLEGAL = 3'd7
  } enc_op_t;

  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

  localparam logic signed [63:0] IMM9_MIN  = -64'sd256;
  localparam logic signed [63:0] IMM9_MAX  =  64'sd255;
  localparam logic signed [63:0] IMM19_MIN = -64'sd262144;
  localparam logic signed [63:0] IMM19_MAX =  64'sd262143;

  // True when value survives truncation to a field whose sign-extended range is [lo, hi].
  function automatic logic fits_signed(input logic signed [63:0] value,
                                       input logic signed [63:0] lo,
                                       input logic signed [63:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational field packer: turns an op/register/immediate bundle into a 32-bit LEGv8 word
// and flags out-of-range immediates and the illegal op code.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [63:0] imm,
  output logic [31:0] instr,
  output logic        err
);

  enc_op_t op_e;
  assign op_e = enc_op_t'(op);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    instr = 32'h0;
    err   = 1'b0;
    case (op_e)
      OP_LDUR: begin
        instr = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
        err   = !fits_signed(imm, IMM9_MIN, IMM9_MAX);
      end
      OP_STUR: begin
        instr = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
        err   = !fits_signed(imm, IMM9_MIN, IMM9_MAX);
      end
      OP_CBZ: begin
        instr = {OPC_CBZ, imm[18:0], rd};
        err   = !fits_signed(imm, IMM19_MIN, IMM19_MAX);
      end
      OP_ADD:  instr = {OPC_ADD, rm, 6'b0, rn, rd};
      OP_SUB:  instr = {OPC_SUB, rm, 6'b0, rn, rd};
      OP_AND:  instr = {OPC_AND, rm, 6'b0, rn, rd};
      OP_ORR:  instr = {OPC_ORR, rm, 6'b0, rn, rd};
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming LEGv8 encoder: one valid/ready output register stage plus word-address and error counters.
// Optional build macro INSTR_ENCODER_DROP_ERR_EN drops flagged bundles instead of emitting them.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W   = 6,
  parameter int ERRCNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          op,
  input  logic [4:0]          rd,
  input  logic [4:0]          rn,
  input  logic [4:0]          rm,
  input  logic [63:0]         imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic [ADDR_W-1:0]   out_addr,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_count
);

  logic [31:0] pack_instr;
  logic        pack_err;
  logic        accept;
  logic        out_hs;
  logic        load;
  logic        err_inc;

  instr_pack u_pack (
    .op    (op),
    .rd    (rd),
    .rn    (rn),
    .rm    (rm),
    .imm   (imm),
    .instr (pack_instr),
    .err   (pack_err)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

`ifdef INSTR_ENCODER_DROP_ERR_EN
  // Flagged bundles are consumed and counted on accept but never reach the output register.
  assign load    = accept && !pack_err;
  assign err_inc = accept && pack_err;
  assign out_err = 1'b0;
`else
  logic out_err_q;

  assign load    = accept;
  assign err_inc = out_hs && out_err_q;
  assign out_err = out_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_err_q <= 1'b0;
    end else if (load) begin
      out_err_q <= pack_err;
    end
  end
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_instr <= 32'h0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_instr <= pack_instr;
    end else if (out_hs) begin
      out_valid <= 1'b0;
    end
  end

  // Address names the word currently presented; it wraps silently at the imem depth.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_addr <= '0;
    end else if (out_hs) begin
      out_addr <= out_addr + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= '0;
    end else if (err_inc && (err_count != '1)) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: encoding table, back-pressure hold, mid-stream reset,
// address wrap and error-counter saturation. Honours INSTR_ENCODER_DROP_ERR_EN if defined.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [4:0]  rd;
  logic [4:0]  rn;
  logic [4:0]  rm;
  logic [63:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [5:0]  out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  instr_encoder #(.ADDR_W(6), .ERRCNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .rd        (rd),
    .rn        (rn),
    .rm        (rm),
    .imm       (imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_addr  (out_addr),
    .out_err   (out_err),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rn;
    logic [4:0]  rm;
    logic [63:0] imm;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [4:0] d, input logic [4:0] n,
                       input logic [4:0] m, input logic [63:0] i);
    op  = o;
    rd  = d;
    rn  = n;
    rm  = m;
    imm = i;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] exp_addr;
    logic [7:0] exp_ec;
    logic       exp_v;

    //            op    rd  rn  rm  imm                         instr          err
    vecs[0]  = '{3'd0,  1,  2,  0, -64'sd5,                     32'hF85FB041, 1'b0};
    vecs[1]  = '{3'd3,  3,  1,  2, 64'd0,                       32'h8B020023, 1'b0};
    vecs[2]  = '{3'd2,  5,  0,  0, -64'sd2,                     32'hB4FFFFC5, 1'b0};
    vecs[3]  = '{3'd1,  4,  6,  0, 64'd255,                     32'hF80FF0C4, 1'b0};
    vecs[4]  = '{3'd0,  0,  0,  0, 64'd256,                     32'hF8500000, 1'b1};
    vecs[5]  = '{3'd0,  0,  0,  0, -64'sd256,                   32'hF8500000, 1'b0};
    vecs[6]  = '{3'd0,  0,  0,  0, -64'sd257,                   32'hF84FF000, 1'b1};
    vecs[7]  = '{3'd2, 31,  0,  0, 64'd262143,                  32'hB47FFFFF, 1'b0};
    vecs[8]  = '{3'd2,  0,  0,  0, 64'd262144,                  32'hB4800000, 1'b1};
    vecs[9]  = '{3'd2,  0,  0,  0, -64'sd262144,                32'hB4800000, 1'b0};
    vecs[10] = '{3'd4,  3,  1,  2, 64'd0,                       32'hCB020023, 1'b0};
    vecs[11] = '{3'd5,  3,  1,  2, 64'd0,                       32'h8A020023, 1'b0};
    vecs[12] = '{3'd6,  3,  1,  2, 64'd0,                       32'hAA020023, 1'b0};
    vecs[13] = '{3'd7,  3,  1,  2, 64'd0,                       32'h00000000, 1'b1};
    vecs[14] = '{3'd3, 31, 31, 31, 64'hFFFF_FFFF_FFFF_FFFF,     32'h8B1F03FF, 1'b0};
    vecs[15] = '{3'd0,  0,  0,  0, 64'h8000_0000_0000_0000,     32'hF8400000, 1'b1};

    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drive(3'd0, 5'd0, 5'd0, 5'd0, 64'd0);
    tick();
    tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_instr", {32'd0, out_instr}, 64'd0);
    check("rst_out_addr",  {58'd0, out_addr},  64'd0);
    check("rst_out_err",   {63'd0, out_err},   64'd0);
    check("rst_err_count", {56'd0, err_count}, 64'd0);
    reset = 1'b0;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Table: back-to-back bundles with the consumer always ready.
    exp_addr  = '0;
    exp_ec    = '0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].op, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].imm);
      tick();
`ifdef INSTR_ENCODER_DROP_ERR_EN
      exp_v = !vecs[i].exp_err;
      if (vecs[i].exp_err) exp_ec++;
      check($sformatf("v%0d_valid", i), {63'd0, out_valid}, {63'd0, exp_v});
      check($sformatf("v%0d_err", i),   {63'd0, out_err},   64'd0);
      check($sformatf("v%0d_ecnt", i),  {56'd0, err_count}, {56'd0, exp_ec});
`else
      exp_v = 1'b1;
      check($sformatf("v%0d_valid", i), {63'd0, out_valid}, 64'd1);
      check($sformatf("v%0d_err", i),   {63'd0, out_err},   {63'd0, vecs[i].exp_err});
      check($sformatf("v%0d_ecnt", i),  {56'd0, err_count}, {56'd0, exp_ec});
      if (vecs[i].exp_err) exp_ec++;
`endif
      check($sformatf("v%0d_addr", i), {58'd0, out_addr}, {58'd0, exp_addr});
      if (exp_v) begin
        check($sformatf("v%0d_instr", i), {32'd0, out_instr}, {32'd0, vecs[i].exp_instr});
        exp_addr++;
      end
    end
    in_valid = 1'b0;
    tick();
    check("tbl_drain_valid", {63'd0, out_valid}, 64'd0);
    check("tbl_drain_addr",  {58'd0, out_addr},  {58'd0, exp_addr});
    check("tbl_drain_ecnt",  {56'd0, err_count}, 64'd5);

    // Back-pressure: word A held for 5 cycles while B waits at the input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(3'd3, 5'd3, 5'd1, 5'd2, 64'd0);
    tick();
    drive(3'd6, 5'd3, 5'd1, 5'd2, 64'd0);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("hold%0d_in_ready", c), {63'd0, in_ready},  64'd0);
      check($sformatf("hold%0d_valid", c),    {63'd0, out_valid}, 64'd1);
      check($sformatf("hold%0d_instr", c),    {32'd0, out_instr}, 64'h8B020023);
      check($sformatf("hold%0d_addr", c),     {58'd0, out_addr},  {58'd0, exp_addr});
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    exp_addr++;
    check("release_instr", {32'd0, out_instr}, 64'hAA020023);
    check("release_addr",  {58'd0, out_addr},  {58'd0, exp_addr});
    in_valid  = 1'b0;
    out_ready = 1'b0;
    tick();
    check("pending_valid", {63'd0, out_valid}, 64'd1);
    check("pending_addr",  {58'd0, out_addr},  {58'd0, exp_addr});

    // Reset with a word pending: clears before any further clock edge.
    reset = 1'b1;
    #2;
    check("midrst_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_addr",  {58'd0, out_addr},  64'd0);
    check("midrst_ecnt",  {56'd0, err_count}, 64'd0);
    check("midrst_instr", {32'd0, out_instr}, 64'd0);
    reset = 1'b0;
    tick();
    check("postrst_in_ready", {63'd0, in_ready},  64'd1);
    check("postrst_valid",    {63'd0, out_valid}, 64'd0);

    // Address wrap: 65 handshakes from 0; the last word lands on address 0 again.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    drive(3'd3, 5'd1, 5'd1, 5'd1, 64'd0);
    for (int i = 0; i < 65; i++) begin
      tick();
      if (i == 63 || i == 64)
        check($sformatf("wrap%0d_addr", i), {58'd0, out_addr}, 64'(i % 64));
    end
    in_valid = 1'b0;
    tick();
    check("wrap_drain_addr", {58'd0, out_addr}, 64'd1);

    // Error saturation: 300 illegal-op bundles.
    in_valid = 1'b1;
    drive(3'd7, 5'd0, 5'd0, 5'd0, 64'd0);
    tick();
`ifdef INSTR_ENCODER_DROP_ERR_EN
    check("illegal_valid", {63'd0, out_valid}, 64'd0);
`else
    check("illegal_valid", {63'd0, out_valid}, 64'd1);
    check("illegal_instr", {32'd0, out_instr}, 64'd0);
    check("illegal_err",   {63'd0, out_err},   64'd1);
`endif
    for (int i = 1; i < 300; i++) tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("sat_ecnt", {56'd0, err_count}, 64'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
